// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard sequencer.
//   opcode_e   - RV32I major opcodes seen by the decoder
//   fwd_sel_e  - EX operand source select (regfile / EX-MEM / MEM-WB)
//   hz_slot_t  - shadow record of one in-flight instruction
//   fwd_pick() - forwarding source for one EX source register
package hazard_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_AUIPC  = 7'b0010111,
        OP_LUI    = 7'b0110111
    } opcode_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic       is_load;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } hz_slot_t;

    localparam hz_slot_t SLOT_EMPTY = '0;

    // EX/MEM has the younger result, so it is tested first. x0 is never forwarded.
    function automatic fwd_sel_e fwd_pick(hz_slot_t mem_s, hz_slot_t wb_s, logic [4:0] rs);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (rs != 5'd0) begin
            if (mem_s.valid && mem_s.wr && mem_s.rd == rs)
                sel = FWD_EXMEM;
            else if (wb_s.valid && wb_s.wr && wb_s.rd == rs)
                sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_op_class.sv
// hazard_op_class: combinational opcode classifier.
//   opcode_i/rd_idx_i -> writes_rd_o (rd!=0 only), uses_rs1_o, uses_rs2_o, is_load_o.
//   Unknown opcodes classify as touching no registers.
module hazard_op_class
    import hazard_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [4:0] rd_idx_i,
    output logic       writes_rd_o,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o,
    output logic       is_load_o
);

    logic wr_fmt;

    always_comb begin
        wr_fmt     = 1'b0;
        uses_rs1_o = 1'b0;
        uses_rs2_o = 1'b0;
        is_load_o  = 1'b0;
        case (opcode_i)
            OP_LOAD:   begin wr_fmt = 1'b1; uses_rs1_o = 1'b1; is_load_o = 1'b1; end
            OP_STORE:  begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            OP_IMM:    begin wr_fmt = 1'b1; uses_rs1_o = 1'b1; end
            OP_REG:    begin wr_fmt = 1'b1; uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            OP_BRANCH: begin uses_rs1_o = 1'b1; uses_rs2_o = 1'b1; end
            OP_JAL:    wr_fmt = 1'b1;
            OP_JALR:   begin wr_fmt = 1'b1; uses_rs1_o = 1'b1; end
            OP_AUIPC:  wr_fmt = 1'b1;
            OP_LUI:    wr_fmt = 1'b1;
            default:   ;
        endcase
    end

    assign writes_rd_o = wr_fmt && (rd_idx_i != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/bubble sequencer and forwarding select for a
// 5-stage RV32I pipe, plus saturating stall/flush perf counters.
//   in : id_valid_i, id_opcode_i, id_rs1/rs2/rd_idx_i, ex_redirect_i, mem_busy_i
//   out: if_stall_o, id_stall_o, id_flush_o, ex_bubble_o,
//        fwd_rs1_sel_o, fwd_rs2_sel_o, stall_cnt_o, flush_cnt_o
// Priority: mem_busy > ex_redirect > load-use > normal.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [6:0]       id_opcode_i,
    input  logic [4:0]       id_rs1_idx_i,
    input  logic [4:0]       id_rs2_idx_i,
    input  logic [4:0]       id_rd_idx_i,
    input  logic             ex_redirect_i,
    input  logic             mem_busy_i,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             id_flush_o,
    output logic             ex_bubble_o,
    output logic [1:0]       fwd_rs1_sel_o,
    output logic [1:0]       fwd_rs2_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    hz_slot_t ex_q, mem_q, wb_q;
    hz_slot_t ex_d, mem_d, wb_d, id_slot;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic writes_rd, uses_rs1, uses_rs2, is_load;
    logic load_use;
    logic stall, flush, bubble;

    hazard_op_class u_cls (
        .opcode_i    (id_opcode_i),
        .rd_idx_i    (id_rd_idx_i),
        .writes_rd_o (writes_rd),
        .uses_rs1_o  (uses_rs1),
        .uses_rs2_o  (uses_rs2),
        .is_load_o   (is_load)
    );

    // An invalid ID instruction enters EX as an all-zero slot, so its
    // stale register fields can never trigger forwarding.
    always_comb begin
        id_slot = SLOT_EMPTY;
        if (id_valid_i) begin
            id_slot.valid   = 1'b1;
            id_slot.wr      = writes_rd;
            id_slot.is_load = is_load;
            id_slot.rd      = id_rd_idx_i;
            id_slot.rs1     = id_rs1_idx_i;
            id_slot.rs2     = id_rs2_idx_i;
        end
    end

    assign load_use = id_valid_i && ex_q.valid && ex_q.is_load && ex_q.wr &&
                      ((uses_rs1 && id_rs1_idx_i == ex_q.rd) ||
                       (uses_rs2 && id_rs2_idx_i == ex_q.rd));

    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        bubble = 1'b0;
        ex_d   = id_slot;
        mem_d  = ex_q;
        wb_d   = mem_q;
        if (mem_busy_i) begin
            stall = 1'b1;
            ex_d  = ex_q;
            mem_d = mem_q;
            wb_d  = wb_q;
        end else if (ex_redirect_i) begin
            // Squashing the ID instruction also discards any load-use hazard it had.
            flush  = 1'b1;
            bubble = 1'b1;
            ex_d   = SLOT_EMPTY;
        end else if (load_use) begin
            stall  = 1'b1;
            bubble = 1'b1;
            ex_d   = SLOT_EMPTY;
        end
    end

    // Controls are forced low during reset even though the slots are already empty,
    // because mem_busy_i/ex_redirect_i may still be asserted by the neighbours.
    assign if_stall_o    = stall  && !rst_i;
    assign id_stall_o    = stall  && !rst_i;
    assign id_flush_o    = flush  && !rst_i;
    assign ex_bubble_o   = bubble && !rst_i;
    assign fwd_rs1_sel_o = rst_i ? FWD_RF : fwd_pick(mem_q, wb_q, ex_q.rs1);
    assign fwd_rs2_sel_o = rst_i ? FWD_RF : fwd_pick(mem_q, wb_q, ex_q.rs2);
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q        <= SLOT_EMPTY;
            mem_q       <= SLOT_EMPTY;
            wb_q        <= SLOT_EMPTY;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            if (if_stall_o && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
            if (id_flush_o && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             ex_redirect, mem_busy;
    logic             if_stall, id_stall, id_flush, ex_bubble;
    logic [1:0]       fwd1, fwd2;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_opcode_i   (id_opcode),
        .id_rs1_idx_i  (id_rs1),
        .id_rs2_idx_i  (id_rs2),
        .id_rd_idx_i   (id_rd),
        .ex_redirect_i (ex_redirect),
        .mem_busy_i    (mem_busy),
        .if_stall_o    (if_stall),
        .id_stall_o    (id_stall),
        .id_flush_o    (id_flush),
        .ex_bubble_o   (ex_bubble),
        .fwd_rs1_sel_o (fwd1),
        .fwd_rs2_sel_o (fwd2),
        .stall_cnt_o   (stall_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    // {valid, opcode, rs1, rs2, rd}
    typedef logic [22:0] instr_t;
    function automatic instr_t LW(input logic [4:0] rd, input logic [4:0] rs1);
        return {1'b1, 7'b0000011, rs1, 5'd0, rd};
    endfunction
    function automatic instr_t ADD(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {1'b1, 7'b0110011, rs1, rs2, rd};
    endfunction
    localparam instr_t NOP = '0;

    // Expected per-cycle response: {if_stall, id_stall, flush, bubble}, fwd selects, counters.
    typedef struct {
        int               step;
        logic [3:0]       ctrl;
        logic [1:0]       f1;
        logic [1:0]       f2;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    int               step_no = 0;
    logic [CNT_W-1:0] exp_sc = '0;
    logic [CNT_W-1:0] exp_fc = '0;

    // Drive one cycle of inputs and queue the hand-computed response for that cycle.
    task automatic step(input instr_t ins, input logic redir, input logic busy, input logic r,
                        input logic [3:0] ctrl, input logic [1:0] f1, input logic [1:0] f2);
        exp_t e;
        @(posedge clk);
        #1;
        {id_valid, id_opcode, id_rs1, id_rs2, id_rd} = ins;
        ex_redirect = redir;
        mem_busy    = busy;
        rst         = r;
        if (r) begin
            exp_sc = '0;
            exp_fc = '0;
        end
        e.step = step_no;
        e.ctrl = ctrl;
        e.f1   = f1;
        e.f2   = f2;
        e.sc   = exp_sc;
        e.fc   = exp_fc;
        q.push_back(e);
        step_no++;
        if (!r) begin
            if (ctrl[3] && exp_sc != CMAX) exp_sc = exp_sc + 1'b1;
            if (ctrl[1] && exp_fc != CMAX) exp_fc = exp_fc + 1'b1;
        end
    endtask

    // Monitor: every cycle with a pending expectation, compare mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if ({if_stall, id_stall, id_flush, ex_bubble} !== e.ctrl) begin
                failures++;
                $display("FAIL ctrl step=%0d got=%b exp=%b", e.step,
                         {if_stall, id_stall, id_flush, ex_bubble}, e.ctrl);
            end
            checks++;
            if (fwd1 !== e.f1 || fwd2 !== e.f2) begin
                failures++;
                $display("FAIL fwd step=%0d got=%0d/%0d exp=%0d/%0d", e.step, fwd1, fwd2, e.f1, e.f2);
            end
            checks++;
            if (stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                failures++;
                $display("FAIL cnt step=%0d got=%0d/%0d exp=%0d/%0d", e.step,
                         stall_cnt, flush_cnt, e.sc, e.fc);
            end
        end
    end

    initial begin
        rst = 1'b1;
        {id_valid, id_opcode, id_rs1, id_rs2, id_rd} = NOP;
        ex_redirect = 1'b0;
        mem_busy    = 1'b0;

        // Reset state, with a redirect and busy pending: everything stays 0.
        step(NOP, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0, 2'd0);
        step(NOP, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);

        // 1. lw x5,0(x1); add x6,x5,x2 -> one load-use stall, then MEM/WB forward.
        step(LW(5, 1),     1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b0, 1'b0, 1'b0, 4'b1101, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(NOP,          1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 2'd0);

        // 2. add x5,x1,x2; sub x7,x5,x5 -> no stall, both operands from EX/MEM.
        step(ADD(5, 1, 2), 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(ADD(7, 5, 5), 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(NOP,          1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 2'd1);
        step(NOP,          1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);

        // 3. lw x0 then add x6,x0,x0 -> no stall, no forwarding.
        step(LW(0, 1),     1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(ADD(6, 0, 0), 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(NOP,          1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);

        // 4. Redirect during a load-use -> flush+bubble only; flush_cnt goes 0->1.
        step(LW(5, 1),     1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b1, 1'b0, 1'b0, 4'b0011, 2'd0, 2'd0);
        step(NOP,          1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(NOP,          1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);

        // 5. Clear counters, then busy x3 over a load-use, then the load-use stall: stall_cnt=4.
        step(NOP,          1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 2'd0);
        step(LW(5, 1),     1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++)
            step(ADD(6, 5, 2), 1'b0, 1'b1, 1'b0, 4'b1100, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b0, 1'b0, 1'b0, 4'b1101, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(NOP,          1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 2'd0);

        // 6. Reset mid-stall -> immediate zeros; first cycle after reset is normal.
        step(LW(5, 1),     1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b0, 1'b1, 1'b0, 4'b1100, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 2'd0);
        step(ADD(6, 5, 2), 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        // Preload stall_cnt to all-ones-minus-one, then 3 more stalls saturate it.
        for (int i = 0; i < 14; i++)
            step(NOP, 1'b0, 1'b1, 1'b0, 4'b1100, 2'd0, 2'd0);
        for (int i = 0; i < 3; i++)
            step(NOP, 1'b0, 1'b1, 1'b0, 4'b1100, 2'd0, 2'd0);
        step(NOP, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);
        step(NOP, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
